v_row_packer: RTL and testbench

Upstream feeder of the V-vector FIFO. Accepts V-matrix data from the memory controller's narrow read stream, one beat at a time, and packs consecutive beats into full `V_VECTOR_T` rows. Each completed row is written into the V FIFO through its `write_enable`/`sram_ready` handshake. A `start` command loads a programmed row count; `done` pulses after the last row is accepted downstream.

---
 rtl/v_row_packer_pkg.sv | 24 ++
 rtl/v_row_packer_assembler.sv | 54 +++++
 rtl/v_row_packer.sv | 146 ++++++++++++++
 tb/tb_v_row_packer.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/v_row_packer_pkg.sv
// Shared definitions for the V-row packer: element, beat and row types plus FSM states.
`ifndef MAX_SEQ_LENGTH
`define MAX_SEQ_LENGTH 16
`endif

package v_row_packer_pkg;

  localparam int V_ELEM_W      = 8;
  localparam int HEAD_DIM      = 64;
  localparam int V_BEAT_ELEMS  = 8;
  localparam int BEATS_PER_ROW = HEAD_DIM / V_BEAT_ELEMS;

  typedef logic [V_ELEM_W-1:0]         V_ELEM_T;
  typedef V_ELEM_T [V_BEAT_ELEMS-1:0]  V_BEAT_T;
  typedef V_ELEM_T [HEAD_DIM-1:0]      V_VECTOR_T;

  typedef enum logic [1:0] {
    V_IDLE,
    V_FILL,
    V_DRAIN,
    V_DONE
  } V_PACKER_STATE_T;

endpackage

// File: rtl/v_row_packer_assembler.sv
// Beat-to-row assembly stage: beat counter, partial-row register and row-complete flag.
module v_row_assembler
  import v_row_packer_pkg::*;
#(
  parameter int BEAT_ELEMS = V_BEAT_ELEMS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     beat_fire,
  input  V_ELEM_T [BEAT_ELEMS-1:0] beat_data,
  output logic                     last_beat,
  output logic                     row_complete,
  output V_VECTOR_T                row_next
);

  localparam int BPR = HEAD_DIM / BEAT_ELEMS;
  localparam int BCW = (BPR > 1) ? $clog2(BPR) : 1;

  logic [BCW-1:0] beat_cnt;
  V_VECTOR_T      asm_row;

  assign last_beat    = (beat_cnt == BCW'(BPR - 1));
  assign row_complete = beat_fire && last_beat;

  // Current row with the incoming beat merged at its slot; the top captures this on the final beat.
  always_comb begin
    row_next = asm_row;
    for (int k = 0; k < BPR; k++) begin
      if (beat_cnt == BCW'(k)) begin
        row_next[k*BEAT_ELEMS +: BEAT_ELEMS] = beat_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_cnt <= '0;
      asm_row  <= '0;
    end else if (clear) begin
      beat_cnt <= '0;
      asm_row  <= '0;
    end else if (beat_fire) begin
      if (last_beat) begin
        beat_cnt <= '0;
        asm_row  <= '0;
      end else begin
        beat_cnt <= beat_cnt + BCW'(1);
        asm_row  <= row_next;
      end
    end
  end

endmodule

// File: rtl/v_row_packer.sv
// Packs narrow V-matrix beats into full rows and writes them into the V FIFO.
// Optional V_PACKER_ABORT_EN adds an abort input that returns the packer to IDLE.
module v_row_packer
  import v_row_packer_pkg::*;
#(
  parameter  int NUM_ENTRIES = `MAX_SEQ_LENGTH,
  parameter  int BEAT_ELEMS  = V_BEAT_ELEMS,
  localparam int CW          = $clog2(NUM_ENTRIES) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
`ifdef V_PACKER_ABORT_EN
  input  logic                     abort,
`endif
  input  logic                     start,
  input  logic [CW-1:0]            num_rows,
  output logic                     busy,
  output logic                     done,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  V_ELEM_T [BEAT_ELEMS-1:0] in_data,
  output logic                     write_enable,
  input  logic                     sram_ready,
  output V_VECTOR_T                write_data,
  output logic [CW-1:0]            rows_written
);

  localparam logic [CW-1:0] MAX_ROWS = CW'(NUM_ENTRIES);

  V_PACKER_STATE_T state, state_next;
  logic [CW-1:0]   target, target_next;
  logic [CW-1:0]   rows_asm, rows_asm_next;
  logic [CW-1:0]   rows_written_next;
  logic            out_full, out_full_next;
  V_VECTOR_T       out_row_next;
  logic [CW-1:0]   num_clamped;
  logic            abort_hit;
  logic            out_fire;
  logic            beat_fire;
  logic            asm_clear;
  logic            last_beat;
  logic            row_complete;
  V_VECTOR_T       row_next;

`ifdef V_PACKER_ABORT_EN
  assign abort_hit = abort && (state != V_IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  assign num_clamped  = (num_rows > MAX_ROWS) ? MAX_ROWS : num_rows;
  assign out_fire     = out_full && sram_ready;
  assign write_enable = out_full;
  assign busy         = (state != V_IDLE);
  assign done         = (state == V_DONE);
  assign beat_fire    = in_valid && in_ready;
  assign asm_clear    = (state == V_IDLE) || abort_hit;

  // The final beat may only land if the output slot is free or is being emptied this cycle.
  assign in_ready = (state == V_FILL) && (rows_asm < target)
                    && !(last_beat && out_full && !sram_ready);

  v_row_assembler #(
    .BEAT_ELEMS (BEAT_ELEMS)
  ) u_assembler (
    .clk          (clk),
    .rst          (rst),
    .clear        (asm_clear),
    .beat_fire    (beat_fire),
    .beat_data    (in_data),
    .last_beat    (last_beat),
    .row_complete (row_complete),
    .row_next     (row_next)
  );

  always_comb begin
    state_next        = state;
    target_next       = target;
    rows_asm_next     = rows_asm;
    rows_written_next = rows_written + {{(CW-1){1'b0}}, out_fire};
    out_full_next     = out_full;
    out_row_next      = write_data;

    if (row_complete) begin
      out_full_next = 1'b1;
      out_row_next  = row_next;
    end else if (out_fire) begin
      out_full_next = 1'b0;
    end

    case (state)
      V_IDLE: begin
        if (start) begin
          target_next       = num_clamped;
          rows_asm_next     = '0;
          rows_written_next = '0;
          // A zero-row load still takes one DRAIN cycle so done lands two cycles after start.
          state_next        = (num_clamped != '0) ? V_FILL : V_DRAIN;
        end
      end
      V_FILL: begin
        if (row_complete) begin
          rows_asm_next = rows_asm + CW'(1);
          if (rows_asm + CW'(1) == target) begin
            state_next = V_DRAIN;
          end
        end
      end
      V_DRAIN: begin
        if ((rows_written_next == target) && !out_full_next) begin
          state_next = V_DONE;
        end
      end
      V_DONE: begin
        state_next = V_IDLE;
      end
      default: begin
        state_next = V_IDLE;
      end
    endcase

    if (abort_hit) begin
      state_next    = V_IDLE;
      out_full_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= V_IDLE;
      target       <= '0;
      rows_asm     <= '0;
      rows_written <= '0;
      out_full     <= 1'b0;
      write_data   <= '0;
    end else begin
      state        <= state_next;
      target       <= target_next;
      rows_asm     <= rows_asm_next;
      rows_written <= rows_written_next;
      out_full     <= out_full_next;
      write_data   <= out_row_next;
    end
  end

endmodule

// File: tb/tb_v_row_packer.sv
// Self-checking bench for v_row_packer: random beats and stalls checked against a row-level model.
module tb_v_row_packer;
  import v_row_packer_pkg::*;

  localparam int NE  = 16;
  localparam int CW  = $clog2(NE) + 1;
  localparam int BPR = BEATS_PER_ROW;

  logic            clk;
  logic            rst;
  logic            start;
  logic [CW-1:0]   num_rows;
  logic            busy;
  logic            done;
  logic            in_valid;
  logic            in_ready;
  V_BEAT_T         in_data;
  logic            write_enable;
  logic            sram_ready;
  V_VECTOR_T       write_data;
  logic [CW-1:0]   rows_written;
`ifdef V_PACKER_ABORT_EN
  logic            abort;
`endif

  v_row_packer #(
    .NUM_ENTRIES (NE),
    .BEAT_ELEMS  (V_BEAT_ELEMS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
`ifdef V_PACKER_ABORT_EN
    .abort        (abort),
`endif
    .start        (start),
    .num_rows     (num_rows),
    .busy         (busy),
    .done         (done),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .write_enable (write_enable),
    .sram_ready   (sram_ready),
    .write_data   (write_data),
    .rows_written (rows_written)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Stimulus knobs and recorded observations.
  int        vprob = 100;
  int        rprob = 100;
  bit        seq_data = 0;
  bit        stall_armed = 0;
  int        stall_left = 0;
  V_BEAT_T   src_q[$];
  V_BEAT_T   gen[$];
  int        acc_cyc[$];
  int        wr_cyc[$];
  V_VECTOR_T wr_data[$];
  int        done_cyc[$];
  int        start_cyc;
  logic      busy_after_start;
  logic      ready_after_start;
  bit        hold_valid = 0;
  V_VECTOR_T hold_row;
  int        hold_bad = 0;

  function automatic V_VECTOR_T exp_row(input int r);
    V_VECTOR_T v;
    v = '0;
    for (int k = 0; k < BPR; k++)
      for (int e = 0; e < V_BEAT_ELEMS; e++)
        v[k*V_BEAT_ELEMS + e] = gen[r*BPR + k][e];
    return v;
  endfunction

  // One clock: drive at negedge, observe handshakes, advance through the posedge.
  task automatic step();
    if (stall_armed && write_enable) begin
      stall_left  = 20;
      stall_armed = 0;
    end
    if (stall_left > 0) begin
      sram_ready = 1'b0;
      stall_left--;
    end else begin
      sram_ready = ($urandom_range(99) < rprob);
    end
    in_valid = (src_q.size() > 0) && ($urandom_range(99) < vprob);
    in_data  = (src_q.size() > 0) ? src_q[0] : '0;
    #1;
    if (in_valid && in_ready) begin
      void'(src_q.pop_front());
      acc_cyc.push_back(cyc);
    end
    if (hold_valid && write_enable && (write_data !== hold_row)) hold_bad++;
    hold_valid = write_enable && !sram_ready;
    hold_row   = write_data;
    if (write_enable && sram_ready) begin
      wr_data.push_back(write_data);
      wr_cyc.push_back(cyc);
      $display("cyc %0d: write row %0d low_word=%08h", cyc, wr_cyc.size() - 1, write_data[3:0]);
    end
    if (done) done_cyc.push_back(cyc);
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic clear_logs();
    acc_cyc.delete();
    wr_cyc.delete();
    wr_data.delete();
    done_cyc.delete();
    hold_valid = 0;
    hold_bad   = 0;
  endtask

  // Runs one load of n rows until done (or until stop_acc beats accepted when stop_acc >= 0).
  task automatic do_load(input int n, input int stop_acc, output bit timed_out);
    V_BEAT_T bt;
    clear_logs();
    src_q.delete();
    gen.delete();
    for (int b = 0; b < n * BPR; b++) begin
      for (int e = 0; e < V_BEAT_ELEMS; e++)
        bt[e] = seq_data ? V_ELEM_T'(b * V_BEAT_ELEMS + e) : V_ELEM_T'($urandom);
      src_q.push_back(bt);
      gen.push_back(bt);
    end
    num_rows  = CW'(n);
    start     = 1'b1;
    start_cyc = cyc;
    step();
    start = 1'b0;
    busy_after_start  = busy;
    ready_after_start = in_ready;
    timed_out = 1;
    for (int c = 0; c < 3000; c++) begin
      if (stop_acc >= 0 && acc_cyc.size() >= stop_acc) begin
        timed_out = 0;
        break;
      end
      if (done_cyc.size() > 0) begin
        timed_out = 0;
        break;
      end
      step();
    end
    $display("load n=%0d: beats=%0d writes=%0d rows_written=%0d", n, acc_cyc.size(), wr_cyc.size(), rows_written);
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; num_rows = '0; in_valid = 1'b0; in_data = '0; sram_ready = 1'b0;
`ifdef V_PACKER_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b want=0", done); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%0b want=0", in_ready); end
    total++; if (write_enable !== 1'b0) begin bad++; $display("FAIL reset_we got=%0b want=0", write_enable); end
    total++; if (write_data !== '0) begin bad++; $display("FAIL reset_wdata got=%h want=0", write_data[3:0]); end
    total++; if (rows_written !== '0) begin bad++; $display("FAIL reset_rows got=%0d want=0", rows_written); end
  endtask

  task automatic test_single_row();
    bit to;
    vprob = 100; rprob = 100; seq_data = 1;
    do_load(1, -1, to);
    seq_data = 0;
    total++; if (to) begin bad++; $display("FAIL single_timeout got=timeout want=done"); end
    total++; if (busy_after_start !== 1'b1) begin bad++; $display("FAIL single_busy_t1 got=%0b want=1", busy_after_start); end
    total++; if (ready_after_start !== 1'b1) begin bad++; $display("FAIL single_ready_t1 got=%0b want=1", ready_after_start); end
    total++;
    if (wr_cyc.size() != 1 || acc_cyc.size() != BPR) begin
      bad++; $display("FAIL single_counts got=writes %0d beats %0d want=1 %0d", wr_cyc.size(), acc_cyc.size(), BPR);
    end else begin
      total++; if (wr_cyc[0] != acc_cyc[BPR-1] + 1) begin bad++; $display("FAIL single_latency got=%0d want=%0d", wr_cyc[0], acc_cyc[BPR-1] + 1); end
      total++; if (wr_data[0] !== exp_row(0)) begin bad++; $display("FAIL single_data got=%h want=%h", wr_data[0], exp_row(0)); end
      total++; if (wr_data[0][63] !== 8'h3F) begin bad++; $display("FAIL single_elem63 got=%h want=3f", wr_data[0][63]); end
      total++; if (done_cyc.size() != 1 || done_cyc[0] != wr_cyc[0] + 1) begin bad++; $display("FAIL single_done got=%0d want=%0d", done_cyc.size() > 0 ? done_cyc[0] : -1, wr_cyc[0] + 1); end
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_after got=%0b want=0", busy); end
    total++; if (rows_written !== CW'(1)) begin bad++; $display("FAIL single_rows got=%0d want=1", rows_written); end
  endtask

  task automatic test_back_to_back();
    bit to;
    vprob = 100; rprob = 100;
    do_load(4, -1, to);
    total++;
    if (to || wr_cyc.size() != 4 || acc_cyc.size() != 4 * BPR) begin
      bad++; $display("FAIL b2b_counts got=writes %0d beats %0d want=4 %0d", wr_cyc.size(), acc_cyc.size(), 4 * BPR);
    end else begin
      total++; if (acc_cyc[0] != start_cyc + 1) begin bad++; $display("FAIL b2b_first_beat got=%0d want=%0d", acc_cyc[0], start_cyc + 1); end
      total++; if (acc_cyc[4*BPR-1] - acc_cyc[0] != 4 * BPR - 1) begin bad++; $display("FAIL b2b_beat_span got=%0d want=%0d", acc_cyc[4*BPR-1] - acc_cyc[0], 4 * BPR - 1); end
      for (int r = 0; r < 4; r++) begin
        total++; if (wr_data[r] !== exp_row(r)) begin bad++; $display("FAIL b2b_data row=%0d got=%h want=%h", r, wr_data[r][3:0], exp_row(r)[3:0]); end
        if (r > 0) begin
          total++; if (wr_cyc[r] - wr_cyc[r-1] != BPR) begin bad++; $display("FAIL b2b_spacing row=%0d got=%0d want=%0d", r, wr_cyc[r] - wr_cyc[r-1], BPR); end
        end
      end
    end
    total++; if (rows_written !== CW'(4)) begin bad++; $display("FAIL b2b_rows got=%0d want=4", rows_written); end
  endtask

  task automatic test_stall();
    bit to;
    vprob = 100; rprob = 100; stall_armed = 1;
    do_load(3, -1, to);
    total++;
    if (to || wr_cyc.size() != 3 || acc_cyc.size() != 3 * BPR) begin
      bad++; $display("FAIL stall_counts got=writes %0d beats %0d want=3 %0d", wr_cyc.size(), acc_cyc.size(), 3 * BPR);
    end else begin
      total++; if (wr_cyc[0] != acc_cyc[BPR-1] + 21) begin bad++; $display("FAIL stall_first_write got=%0d want=%0d", wr_cyc[0], acc_cyc[BPR-1] + 21); end
      total++; if (acc_cyc[2*BPR-2] != acc_cyc[BPR-1] + BPR - 1) begin bad++; $display("FAIL stall_row1_fill got=%0d want=%0d", acc_cyc[2*BPR-2], acc_cyc[BPR-1] + BPR - 1); end
      total++; if (acc_cyc[2*BPR-1] != wr_cyc[0]) begin bad++; $display("FAIL stall_final_beat got=%0d want=%0d", acc_cyc[2*BPR-1], wr_cyc[0]); end
      total++; if (wr_data[0] !== exp_row(0)) begin bad++; $display("FAIL stall_row0 got=%h want=%h", wr_data[0][3:0], exp_row(0)[3:0]); end
      total++; if (wr_data[1] !== exp_row(1)) begin bad++; $display("FAIL stall_row1 got=%h want=%h", wr_data[1][3:0], exp_row(1)[3:0]); end
    end
    total++; if (hold_bad != 0) begin bad++; $display("FAIL stall_hold got=%0d changes want=0", hold_bad); end
  endtask

  task automatic test_clamp_zero();
    bit to;
    vprob = 100; rprob = 100;
    do_load(NE + 5, -1, to);
    total++; if (to || wr_cyc.size() != NE) begin bad++; $display("FAIL clamp_writes got=%0d want=%0d", wr_cyc.size(), NE); end
    total++; if (src_q.size() != 5 * BPR) begin bad++; $display("FAIL clamp_leftover got=%0d want=%0d", src_q.size(), 5 * BPR); end
    total++; if (rows_written !== CW'(NE)) begin bad++; $display("FAIL clamp_rows got=%0d want=%0d", rows_written, NE); end
    do_load(0, -1, to);
    total++; if (to || done_cyc.size() != 1 || done_cyc[0] != start_cyc + 2) begin bad++; $display("FAIL zero_done got=%0d want=%0d", done_cyc.size() > 0 ? done_cyc[0] : -1, start_cyc + 2); end
    total++; if (wr_cyc.size() != 0) begin bad++; $display("FAIL zero_writes got=%0d want=0", wr_cyc.size()); end
    total++; if (busy_after_start !== 1'b1) begin bad++; $display("FAIL zero_busy got=%0b want=1", busy_after_start); end
  endtask

  task automatic test_random();
    bit to;
    int n;
    vprob = 70; rprob = 60;
    for (int it = 0; it < 4; it++) begin
      n = $urandom_range(6, 1);
      do_load(n, -1, to);
      total++; if (to || wr_cyc.size() != n) begin bad++; $display("FAIL rand_writes it=%0d got=%0d want=%0d", it, wr_cyc.size(), n); end
      for (int r = 0; r < n && r < wr_data.size(); r++) begin
        total++; if (wr_data[r] !== exp_row(r)) begin bad++; $display("FAIL rand_data it=%0d row=%0d got=%h want=%h", it, r, wr_data[r][3:0], exp_row(r)[3:0]); end
      end
      total++; if (rows_written !== CW'(n)) begin bad++; $display("FAIL rand_rows it=%0d got=%0d want=%0d", it, rows_written, n); end
      total++; if (hold_bad != 0) begin bad++; $display("FAIL rand_hold it=%0d got=%0d want=0", it, hold_bad); end
      if (wr_cyc.size() > 0 && done_cyc.size() > 0) begin
        total++; if (done_cyc[0] != wr_cyc[wr_cyc.size()-1] + 1) begin bad++; $display("FAIL rand_done it=%0d got=%0d want=%0d", it, done_cyc[0], wr_cyc[wr_cyc.size()-1] + 1); end
      end
    end
    vprob = 100; rprob = 100;
  endtask

  task automatic test_reset_mid_row();
    bit to;
    vprob = 100; rprob = 100;
    do_load(3, 2 * BPR + 3, to);
    total++; if (to) begin bad++; $display("FAIL rstmid_reach got=timeout want=19 beats"); end
    rst = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0) begin bad++; $display("FAIL rstmid_ctrl got=busy %0b done %0b rdy %0b want=0 0 0", busy, done, in_ready); end
    total++; if (write_enable !== 1'b0 || write_data !== '0) begin bad++; $display("FAIL rstmid_out got=we %0b data %h want=0 0", write_enable, write_data[3:0]); end
    total++; if (rows_written !== '0) begin bad++; $display("FAIL rstmid_rows got=%0d want=0", rows_written); end
    @(negedge clk);
    rst = 1'b1;
    clear_logs();
    repeat (5) step();
    total++; if (wr_cyc.size() != 0) begin bad++; $display("FAIL rstmid_nowrite got=%0d want=0", wr_cyc.size()); end
    do_load(1, -1, to);
    total++; if (to || wr_cyc.size() != 1) begin bad++; $display("FAIL rstmid_fresh_writes got=%0d want=1", wr_cyc.size()); end
    else begin
      total++; if (wr_data[0] !== exp_row(0)) begin bad++; $display("FAIL rstmid_fresh_data got=%h want=%h", wr_data[0][3:0], exp_row(0)[3:0]); end
    end
  endtask

`ifdef V_PACKER_ABORT_EN
  task automatic test_abort();
    bit to;
    vprob = 100; rprob = 100;
    do_load(3, BPR + 2, to);
    abort = 1'b1;
    step();
    abort = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%0b want=0", busy); end
    total++; if (write_enable !== 1'b0) begin bad++; $display("FAIL abort_we got=%0b want=0", write_enable); end
    repeat (4) step();
    total++; if (done_cyc.size() != 0) begin bad++; $display("FAIL abort_done got=%0d pulses want=0", done_cyc.size()); end
    total++; if (rows_written !== CW'(1)) begin bad++; $display("FAIL abort_rows got=%0d want=1", rows_written); end
    total++; if (wr_cyc.size() != 1) begin bad++; $display("FAIL abort_writes got=%0d want=1", wr_cyc.size()); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_row();
    test_back_to_back();
    test_stall();
    test_clamp_zero();
    test_random();
    test_reset_mid_row();
`ifdef V_PACKER_ABORT_EN
    test_abort();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
